// File: rtl/uart_frame_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared constants and helpers for the UART frame shift datapath.
//           Parity mode encodings and the frame-width calculation used by
//           both the shift register and any surrounding baud/FIFO logic.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Start bit + data bits + optional parity bit + stop bits.
    function automatic int uart_frame_width(input int data_bits,
                                            input int parity_mode,
                                            input int stop_bits);
        return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_shift_bit_counter.sv
`default_nettype none
// ============================================================================
// Module  : uart_bit_counter
// Purpose : Bit-time counter for one UART frame. Counts inc strobes from 0
//           to FW-1 and wraps, flagging the wrap combinationally so the
//           parent can register frame completion in the same edge.
// Ports   : clk, rst (async, active-high)
//           clr     - synchronous clear to 0
//           restart - synchronous restart to 0 (frame load)
//           inc     - advance one bit time
//           wrap    - high when this inc completes the frame
// Rev     : 1.0  initial release
// ============================================================================
module uart_bit_counter #(
    parameter int FW = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic restart,
    input  logic inc,
    output logic wrap
);

    localparam int CW = $clog2(FW + 1);
    localparam logic [CW-1:0] c_last = CW'(FW - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == c_last);
    // clr and restart take priority over inc, so they also suppress the wrap.
    assign wrap      = inc & ~clr & ~restart & w_at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr || restart) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_frame_shift.sv
`default_nettype none
// ============================================================================
// Module  : uart_frame_shift
// Purpose : UART frame shift register shared by RX and TX. Serial data
//           enters at the MSB and leaves at q[0] (LSB-first framing). TX
//           loads a fully framed word; RX shifts the line in and gets
//           parity/framing checks when the frame completes.
// Macro   : UART_FRAME_SHIFT_ERR_EN - when defined, parity_err/frame_err are
//           computed; otherwise they are tied low and the checker is absent.
// Ports   : clk, rst (async, active-high), clr (sync clear)
//           load/load_data - TX frame load, restarts bit counter
//           shift/sdi      - one bit time, sdi enters q[FW-1]
//           sdo            - q[0] while busy, idle high otherwise
//           q, data_out    - raw frame and its data field
//           busy, frame_done, parity_err, frame_err - status
// Rev     : 1.0  initial release
// ============================================================================
module uart_frame_shift
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    localparam int FW         = uart_frame_width(DATA_BITS, PARITY_MODE, STOP_BITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 shift,
    input  logic                 sdi,
    output logic                 sdo,
    output logic [FW-1:0]        q,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic                 frame_err
);

    logic [FW-1:0] r_q;
    logic          r_busy;
    logic          r_frame_done;
    logic [FW-1:0] w_shifted;
    logic [FW-1:0] w_load_frame;
    logic          w_wrap;

    assign w_shifted = {sdi, r_q[FW-1:1]};

    // Framed TX word: stop bits, optional parity, payload, start bit.
    generate
        if (PARITY_MODE != PARITY_NONE) begin : g_par
            logic w_tx_parity;
            assign w_tx_parity  = (PARITY_MODE == PARITY_ODD) ? ~(^load_data) : ^load_data;
            assign w_load_frame = {{STOP_BITS{1'b1}}, w_tx_parity, load_data, 1'b0};
        end else begin : g_nopar
            assign w_load_frame = {{STOP_BITS{1'b1}}, load_data, 1'b0};
        end
    endgenerate

    uart_bit_counter #(
        .FW (FW)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .restart (load),
        .inc     (shift),
        .wrap    (w_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q          <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (clr) begin
            r_q          <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (load) begin
            // A simultaneous shift is ignored: the new frame starts intact.
            r_q          <= w_load_frame;
            r_busy       <= 1'b1;
            r_frame_done <= 1'b0;
        end else if (shift) begin
            r_q          <= w_shifted;
            r_busy       <= ~w_wrap;
            r_frame_done <= w_wrap;
        end else begin
            r_frame_done <= 1'b0;
        end
    end

`ifdef UART_FRAME_SHIFT_ERR_EN
    logic r_parity_err;
    logic r_frame_err;
    logic w_frame_err_chk;
    logic w_parity_err_chk;

    // Checks look at the frame as it will be after the completing shift.
    assign w_frame_err_chk = w_shifted[0] | ~(&w_shifted[FW-1 -: STOP_BITS]);

    generate
        if (PARITY_MODE != PARITY_NONE) begin : g_par_chk
            logic w_xor;
            assign w_xor            = ^w_shifted[DATA_BITS+1:1];
            assign w_parity_err_chk = (PARITY_MODE == PARITY_ODD) ? ~w_xor : w_xor;
        end else begin : g_nopar_chk
            assign w_parity_err_chk = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else if (clr || load) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else if (w_wrap) begin
            r_parity_err <= w_parity_err_chk;
            r_frame_err  <= w_frame_err_chk;
        end
    end

    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
`else
    assign parity_err = 1'b0;
    assign frame_err  = 1'b0;
`endif

    assign q          = r_q;
    assign data_out   = r_q[DATA_BITS:1];
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign sdo        = r_busy ? r_q[0] : 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_shift.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_frame_shift
// Purpose : Self-checking bench for uart_frame_shift with 8 data bits, even
//           parity and one stop bit (11-bit frame). Directed TX table, RX
//           error frames, mid-frame load, async reset, then random traffic
//           against a frame-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_frame_shift;

    localparam int FW = 11;
`ifdef UART_FRAME_SHIFT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clr, load, shift, sdi;
    logic [7:0]  load_data;
    logic        sdo, busy, frame_done, parity_err, frame_err;
    logic [10:0] q;
    logic [7:0]  data_out;

    int checks = 0;
    int errors = 0;

    // Reference model state: the frame as an integer, bits-since-start count.
    int m_frame, m_count;
    bit m_busy, m_fd, m_pe, m_fe;

    uart_frame_shift #(
        .DATA_BITS   (8),
        .PARITY_MODE (1),
        .STOP_BITS   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .load       (load),
        .load_data  (load_data),
        .shift      (shift),
        .sdi        (sdi),
        .sdo        (sdo),
        .q          (q),
        .data_out   (data_out),
        .busy       (busy),
        .frame_done (frame_done),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame = 0; m_count = 0;
        m_busy = 0; m_fd = 0; m_pe = 0; m_fe = 0;
    endtask

    function automatic int even_parity(input int d);
        return $countones(d[7:0]) % 2;
    endfunction

    task automatic model_update(input bit c, input bit l, input int d, input bit s, input bit si);
        int data, par;
        m_fd = 0;
        if (c) begin
            model_reset();
        end else if (l) begin
            m_frame = (1 << 10) | (even_parity(d) << 9) | ((d & 8'hFF) << 1);
            m_count = 0; m_busy = 1; m_pe = 0; m_fe = 0;
        end else if (s) begin
            m_frame = (m_frame >> 1) | (int'(si) << 10);
            m_count = m_count + 1;
            m_busy  = 1;
            if (m_count == FW) begin
                m_count = 0; m_busy = 0; m_fd = 1;
                data = (m_frame >> 1) & 8'hFF;
                par  = (m_frame >> 9) & 1;
                m_pe = ERR_EN && (((($countones(data[7:0]) + par) % 2)) != 0);
                m_fe = ERR_EN && (((m_frame & 1) != 0) || (((m_frame >> 10) & 1) == 0));
            end
        end
    endtask

    task automatic check_model();
        chk("q",          32'(q),          32'(m_frame & 11'h7FF));
        chk("data_out",   32'(data_out),   32'((m_frame >> 1) & 8'hFF));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("sdo",        32'(sdo),        m_busy ? 32'(m_frame & 1) : 32'd1);
        chk("parity_err", 32'(parity_err), 32'(m_pe));
        chk("frame_err",  32'(frame_err),  32'(m_fe));
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic step(input bit c, input bit l, input logic [7:0] d, input bit s, input bit si);
        clr = c; load = l; load_data = d; shift = s; sdi = si;
        model_update(c, l, int'(d), s, si);
        @(posedge clk); #1;
        check_model();
    endtask

    // Clear, then shift in start, data LSB-first, parity bit, stop bit.
    task automatic rx_frame(input logic [7:0] d, input bit st, input bit par, input bit stop);
        step(1, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 1, st);
        for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1, d[i]);
        step(0, 0, 8'h00, 1, par);
        step(0, 0, 8'h00, 1, stop);
    endtask

    typedef struct {
        bit         clr, load;
        logic [7:0] d;
        bit         shift, sdi;
        bit         e_sdo, e_busy, e_fd;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // TX of 0xA5: expected sdo walks 0, A5 LSB-first, parity 0, stop 1.
        tbl[0]  = '{0, 1, 8'hA5, 0, 1, 0, 1, 0};
        tbl[1]  = '{0, 0, 8'h00, 1, 1, 1, 1, 0};
        tbl[2]  = '{0, 0, 8'h00, 1, 1, 0, 1, 0};
        tbl[3]  = '{0, 0, 8'h00, 1, 1, 1, 1, 0};
        tbl[4]  = '{0, 0, 8'h00, 1, 1, 0, 1, 0};
        tbl[5]  = '{0, 0, 8'h00, 1, 1, 0, 1, 0};
        tbl[6]  = '{0, 0, 8'h00, 1, 1, 1, 1, 0};
        tbl[7]  = '{0, 0, 8'h00, 1, 1, 0, 1, 0};
        tbl[8]  = '{0, 0, 8'h00, 1, 1, 1, 1, 0};
        tbl[9]  = '{0, 0, 8'h00, 1, 1, 0, 1, 0};
        tbl[10] = '{0, 0, 8'h00, 1, 1, 1, 1, 0};
        tbl[11] = '{0, 0, 8'h00, 1, 1, 1, 0, 1};
        tbl[12] = '{0, 0, 8'h00, 0, 1, 1, 0, 0};

        rst = 1'b1; clr = 0; load = 0; shift = 0; sdi = 1; load_data = 8'h00;
        model_reset();
        #12;
        chk("reset_q",     32'(q),          32'd0);
        chk("reset_busy",  32'(busy),       32'd0);
        chk("reset_fd",    32'(frame_done), 32'd0);
        chk("reset_sdo",   32'(sdo),        32'd1);
        chk("reset_perr",  32'(parity_err), 32'd0);
        chk("reset_ferr",  32'(frame_err),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed TX table.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].clr, tbl[i].load, tbl[i].d, tbl[i].shift, tbl[i].sdi);
            chk($sformatf("tx_sdo[%0d]", i),  32'(sdo),        32'(tbl[i].e_sdo));
            chk($sformatf("tx_busy[%0d]", i), 32'(busy),       32'(tbl[i].e_busy));
            chk($sformatf("tx_fd[%0d]", i),   32'(frame_done), 32'(tbl[i].e_fd));
            if (i == 0) chk("tx_load_q", 32'(q), 32'h54A);
        end

        // Good RX frame of 0x3C (even parity bit 0).
        rx_frame(8'h3C, 0, 0, 1);
        chk("rx_fd",   32'(frame_done), 32'd1);
        chk("rx_data", 32'(data_out),   32'h3C);
        chk("rx_perr", 32'(parity_err), 32'd0);
        chk("rx_ferr", 32'(frame_err),  32'd0);
        step(0, 0, 8'h00, 0, 1);
        chk("rx_fd_pulse", 32'(frame_done), 32'd0);

        // Bad stop bit, then bad parity; each flag drops on the next clr.
        rx_frame(8'h3C, 0, 0, 0);
        chk("stop_ferr", 32'(frame_err),  32'(ERR_EN));
        chk("stop_perr", 32'(parity_err), 32'd0);
        step(0, 0, 8'h00, 0, 1);
        chk("ferr_held", 32'(frame_err),  32'(ERR_EN));
        rx_frame(8'h3C, 0, 1, 1);
        chk("par_perr", 32'(parity_err), 32'(ERR_EN));
        chk("par_ferr", 32'(frame_err),  32'd0);
        step(1, 0, 8'h00, 0, 1);
        chk("clr_perr", 32'(parity_err), 32'd0);

        // Load with shift mid-frame at count 5.
        step(1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 1'(i));
        step(0, 1, 8'h11, 1, 0);
        chk("midload_q",  32'(q),          32'h422);
        chk("midload_fd", 32'(frame_done), 32'd0);
        for (int i = 0; i < 11; i++) step(0, 0, 8'h00, 1, 1);
        chk("midload_done", 32'(frame_done), 32'd1);

        // Async reset at count 7.
        step(1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1, 0);
        clr = 0; load = 0; shift = 0; sdi = 1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_q",    32'(q),    32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sdo",  32'(sdo),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(0, 0, 8'h00, 0, 1);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
                 8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
